// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM between a fetch port (i_*) and a
// load/store port (d_*), with store lane steering and load extension.
module sram_port_arbiter #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic          d_unsigned,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,

    output logic          sram_ceb,
    output logic          sram_web,
    output logic [DW-1:0] sram_bweb,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_di,
    input  logic [DW-1:0] sram_do
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Handshake: a requester holds req and its payload until it sees gnt=1 in
    // the same cycle; the response (rvalid) follows exactly one cycle later and
    // cannot be stalled by the receiver.

    // rr_q=1 means the d port wins the next tie.
    logic          rr_q, rr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_port_q, rsp_port_d;
    logic          rsp_store_q, rsp_store_d;
    logic          rsp_err_q, rsp_err_d;
    logic [1:0]    rsp_size_q, rsp_size_d;
    logic          rsp_uns_q, rsp_uns_d;
    logic [1:0]    rsp_off_q, rsp_off_d;
    logic [DW-1:0] i_hold_q, i_hold_d;
    logic [DW-1:0] d_hold_q, d_hold_d;

    logic          d_misalign;
    logic          d_access;
    logic          d_store;
    logic [1:0]    d_off;
    logic [DW-1:0] load_shift;
    logic [DW-1:0] load_fmt;
    logic [DW-1:0] d_resp_data;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2]};

    assign d_off = d_addr[1:0];

    // Arbitration
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            i_gnt = i_req && (!d_req || !rr_q);
            d_gnt = d_req && (!i_req ||  rr_q);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (i_gnt) begin
            rr_d = 1'b1;
        end else if (d_gnt) begin
            rr_d = 1'b0;
        end
    end

    always_comb begin
        d_misalign = 1'b0;
        case (d_size)
            SZ_BYTE: d_misalign = 1'b0;
            SZ_HALF: d_misalign = d_off[0];
            default: d_misalign = (d_off != 2'b00);
        endcase
    end

    assign d_access = d_gnt && !d_misalign;
    assign d_store  = d_access && d_we;

    // SRAM command, driven in the grant cycle
    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_di   = '0;
        if (i_gnt) begin
            sram_ceb = 1'b0;
            sram_a   = i_addr[AW+1:2];
        end else if (d_access) begin
            sram_ceb = 1'b0;
            sram_a   = d_addr[AW+1:2];
        end
        if (d_store) begin
            sram_web = 1'b0;
            case (d_size)
                SZ_BYTE: begin
                    sram_di   = {4{d_wdata[7:0]}};
                    sram_bweb = ~(32'h0000_00FF << {d_off, 3'b000});
                end
                SZ_HALF: begin
                    sram_di   = {2{d_wdata[15:0]}};
                    sram_bweb = d_off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                end
                default: begin
                    sram_di   = d_wdata;
                    sram_bweb = '0;
                end
            endcase
        end
    end

    // Response bookkeeping captured at grant time
    always_comb begin
        rsp_valid_d = i_gnt || d_gnt;
        rsp_port_d  = d_gnt;
        rsp_store_d = d_store;
        rsp_err_d   = d_gnt && d_misalign;
        rsp_size_d  = d_gnt ? d_size : SZ_WORD;
        rsp_uns_d   = d_gnt ? d_unsigned : 1'b0;
        rsp_off_d   = d_gnt ? d_off : 2'b00;
    end

    // Load data formatting in the response cycle
    always_comb begin
        load_shift = sram_do >> {rsp_off_q, 3'b000};
        load_fmt   = sram_do;
        case (rsp_size_q)
            SZ_BYTE: load_fmt = rsp_uns_q ? {24'h0, load_shift[7:0]}
                                          : {{24{load_shift[7]}}, load_shift[7:0]};
            SZ_HALF: load_fmt = rsp_uns_q ? {16'h0, load_shift[15:0]}
                                          : {{16{load_shift[15]}}, load_shift[15:0]};
            default: load_fmt = sram_do;
        endcase
        d_resp_data = (rsp_store_q || rsp_err_q) ? '0 : load_fmt;
    end

    assign i_rvalid = !rst && rsp_valid_q && !rsp_port_q;
    assign d_rvalid = !rst && rsp_valid_q &&  rsp_port_q;
    assign d_err    = d_rvalid && rsp_err_q;

    // Read data holds its last value between responses and reads 0 under reset.
    always_comb begin
        i_rdata = i_hold_q;
        d_rdata = d_hold_q;
        if (rst) begin
            i_rdata = '0;
            d_rdata = '0;
        end else begin
            if (i_rvalid) i_rdata = sram_do;
            if (d_rvalid) d_rdata = d_resp_data;
        end
        i_hold_d = i_rdata;
        d_hold_d = d_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_store_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_size_q  <= SZ_WORD;
            rsp_uns_q   <= 1'b0;
            rsp_off_q   <= 2'b00;
            i_hold_q    <= '0;
            d_hold_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_store_q <= rsp_store_d;
            rsp_err_q   <= rsp_err_d;
            rsp_size_q  <= rsp_size_d;
            rsp_uns_q   <= rsp_uns_d;
            rsp_off_q   <= rsp_off_d;
            i_hold_q    <= i_hold_d;
            d_hold_q    <= d_hold_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_unsigned;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        sram_ceb, sram_web;
    logic [31:0] sram_bweb, sram_di, sram_do;
    logic [13:0] sram_a;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(14), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    // Behavioural macro: bit-masked write, registered read.
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web)
                mem[sram_a[5:0]] <= (mem[sram_a[5:0]] & sram_bweb) | (sram_di & ~sram_bweb);
            else
                sram_do <= mem[sram_a[5:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
        d_addr = addr; d_wdata = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        sram_do = 32'h0;
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0;
        d_addr = 32'h14; d_wdata = 32'h0;

        // Reset with both ports requesting
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("rst_i_gnt", i_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_ceb", sram_ceb, 1);
            check("rst_bweb", sram_bweb, 32'hFFFF_FFFF);
            check("rst_d_rdata", d_rdata, 0);
        end
        @(negedge clk);
        rst = 1'b0; idle();
        #1;
        check("idle_ceb", sram_ceb, 1);

        // sw 0x10
        @(negedge clk);
        drive_d(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF); #1;
        check("sw_gnt", d_gnt, 1);
        check("sw_ceb", sram_ceb, 0);
        check("sw_web", sram_web, 0);
        check("sw_bweb", sram_bweb, 32'h0);
        check("sw_a", sram_a, 4);
        check("sw_di", sram_di, 32'hDEAD_BEEF);

        // lw 0x10 issued in the store's response cycle
        @(negedge clk);
        check("sw_rvalid", d_rvalid, 1);
        check("sw_rdata", d_rdata, 0);
        check("sw_err", d_err, 0);
        drive_d(1'b0, 2'd2, 1'b0, 32'h10, 32'h0); #1;
        check("lw_gnt", d_gnt, 1);
        check("lw_web", sram_web, 1);
        check("lw_bweb", sram_bweb, 32'hFFFF_FFFF);
        check("lw_a", sram_a, 4);

        // sb 0x13
        @(negedge clk);
        check("lw_rvalid", d_rvalid, 1);
        check("lw_rdata", d_rdata, 32'hDEAD_BEEF);
        drive_d(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB); #1;
        check("sb_bweb", sram_bweb, 32'h00FF_FFFF);
        check("sb_di", sram_di, 32'hABAB_ABAB);
        check("sb_web", sram_web, 0);

        // lb 0x13
        @(negedge clk);
        check("sb_rvalid", d_rvalid, 1);
        check("sb_rdata", d_rdata, 0);
        drive_d(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        @(negedge clk);
        check("lb_rdata", d_rdata, 32'hFFFF_FFAB);
        drive_d(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        @(negedge clk);
        check("lbu_rdata", d_rdata, 32'h0000_00AB);
        drive_d(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        @(negedge clk);
        check("lh_rdata", d_rdata, 32'hFFFF_ABAD);

        // sh 0x16 then lhu 0x16
        drive_d(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_1234); #1;
        check("sh_bweb", sram_bweb, 32'h0000_FFFF);
        check("sh_di", sram_di, 32'h1234_1234);
        @(negedge clk);
        drive_d(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
        @(negedge clk);
        check("lhu_rdata", d_rdata, 32'h0000_1234);
        idle();
        @(negedge clk);
        check("hold_rvalid", d_rvalid, 0);
        check("hold_rdata", d_rdata, 32'h0000_1234);

        // Misaligned lw 0x11
        drive_d(1'b0, 2'd2, 1'b0, 32'h11, 32'h0); #1;
        check("mis_gnt", d_gnt, 1);
        check("mis_ceb", sram_ceb, 1);
        @(negedge clk);
        idle();
        check("mis_rvalid", d_rvalid, 1);
        check("mis_err", d_err, 1);
        check("mis_rdata", d_rdata, 0);

        // Fetch, then reset in its response cycle drops it
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h10; #1;
        check("fetch_gnt", i_gnt, 1);
        @(negedge clk);
        i_req = 1'b0; rst = 1'b1; #1;
        check("drop_rvalid", i_rvalid, 0);
        check("drop_rdata", i_rdata, 0);
        @(negedge clk);
        check("drop_rvalid2", i_rvalid, 0);

        // Contention straight out of reset: i, d, i, d
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h10;
        drive_d(1'b0, 2'd2, 1'b0, 32'h14, 32'h0); #1;
        check("rr1_i_gnt", i_gnt, 1);
        check("rr1_d_gnt", d_gnt, 0);
        check("rr1_d_rvalid", d_rvalid, 0);
        @(negedge clk); #1;
        check("rr2_i_gnt", i_gnt, 0);
        check("rr2_d_gnt", d_gnt, 1);
        check("rr2_i_rvalid", i_rvalid, 1);
        check("rr2_i_rdata", i_rdata, 32'hABAD_BEEF);
        check("rr2_d_rvalid", d_rvalid, 0);
        @(negedge clk); #1;
        check("rr3_i_gnt", i_gnt, 1);
        check("rr3_d_gnt", d_gnt, 0);
        check("rr3_d_rvalid", d_rvalid, 1);
        check("rr3_d_rdata", d_rdata, 32'h1234_0000);
        check("rr3_i_rvalid", i_rvalid, 0);
        @(negedge clk); #1;
        check("rr4_d_gnt", d_gnt, 1);
        check("rr4_i_rvalid", i_rvalid, 1);
        @(negedge clk);
        idle(); #1;
        check("rr5_d_rvalid", d_rvalid, 1);
        check("rr5_i_rvalid", i_rvalid, 0);
        check("rr5_i_hold", i_rdata, 32'hABAD_BEEF);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
